spi_controller: RTL and testbench
=================================

Name: spi_controller

Overview:
SPI initiator (controller) that generates write frames for the chip's SPI register peripheral. It drives the other end of the peripheral's ncs/sclk/copi interface. It is used in an on-chip/FPGA bench harness and in companion MCU-replacement logic that programs the output-enable, PWM-enable and duty-cycle registers. It accepts one {addr, data} request per valid/ready handshake and serialises it as a 16-bit Mode-0 frame, MSB first.

Parameters:
CLK_DIV, 4, sclk half-period in clk cycles; legal range 3..255. Must be ≥3 so the peripheral's 2-FF sclk synchroniser sees every edge.
CS_SETUP, 2, clk cycles ncs is low before the first sclk rising edge; legal range 1..255.
CS_HOLD, 2, clk cycles ncs stays low after the last sclk falling edge; legal range 1..255.
GAP, 4, clk cycles ncs stays high between frames; legal range 1..255.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request (IDLE only)
req_addr  input  7  register address, frame bits [14:8]
req_data  input  8  write data, frame bits [7:0]
busy  output  1  high from accept until return to IDLE
done  output  1  one-cycle pulse when a frame completes
sclk  output  1  SPI clock; CPOL=0
ncs  output  1  chip select, active low
copi  output  1  controller-out data

Behaviour:
- Reset: asynchronous, active-low. While reset is asserted: ncs=1, sclk=0, copi=0, req_ready=0, busy=0, done=0, state=IDLE. On the first clk after release: req_ready=1.
- All outputs are registered; no combinational path from input to output.
- Frame format: {1'b1 (write), req_addr[6:0], req_data[7:0]}. It is latched on accept (req_valid && req_ready) into a 16-bit shift register. The frame is always transmitted verbatim; the controller does no address range check.
- FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  - IDLE: req_ready=1, ncs=1, sclk=0, copi=0. On accept, go to SETUP next cycle; req_ready=0 and busy=1 from the next cycle.
  - SETUP: ncs=0, sclk=0, copi=frame[15], for CS_SETUP cycles.
  - SHIFT: 16 bit periods of 2*CLK_DIV cycles each. Each period has a low phase (CLK_DIV cycles, sclk=0) followed by a high phase (CLK_DIV cycles, sclk=1). copi holds bit i for the whole period and changes only at the start of a low phase (Mode 0: peripheral samples on rising edge). The bit counter runs 15 down to 0.
  - HOLD: sclk=0, ncs=0, copi=0, for CS_HOLD cycles.
  - GAP: ncs=1, for GAP cycles. done=1 in the first GAP cycle only. busy drops and req_ready rises on the first IDLE cycle.
- Frame timing: ncs low for exactly CS_SETUP + 32*CLK_DIV + CS_HOLD cycles. Accept-to-accept minimum is 1 + that + GAP cycles.
- Exactly 16 sclk rising edges per frame. sclk never toggles while ncs=1.
- req_valid outside IDLE is ignored, and req_addr/req_data changes after accept have no effect. A request held valid is accepted on the first IDLE cycle.
- Reset mid-frame: outputs go to reset values immediately. The partial frame is discarded by the peripheral because ncs rises before 16 bits. No done pulse is generated.
- Counters: phase counter width 8 bits; bit counter 4 bits. No wrap beyond the stated ranges.

Decomposition:
- Shared package spi_pkg:
  - FRAME_W=16, ADDR_W=7, DATA_W=8, RW_WRITE=1'b1.
  - Register addresses: REG_EN_OUT_7_0=7'h00, REG_EN_OUT_15_8=7'h01, REG_EN_PWM_7_0=7'h02, REG_EN_PWM_15_8=7'h03, REG_PWM_DUTY=7'h04.
  - FSM state enum.
- One sub-module, spi_phase_timer: a loadable 8-bit down-counter with a tick output. The FSM uses it for the SETUP, half-period, HOLD and GAP durations.

Test Plan:
1. Defaults; write addr 0x04 data 0x80. Required: copi bits on the 16 rising edges = 1,0000100,10000000; ncs low for 2+128+2=132 cycles; one done pulse. A connected spi_peripheral then shows pwm_duty_cycle=0x80.
2. Write 0x00<-0xFF, then 0x02<-0x0F, with req_valid held continuously. Required: second accept occurs exactly GAP+1 cycles after ncs rises. Peripheral en_reg_out_7_0=0xFF and en_reg_pwm_7_0=0x0F; uo_out=0xFF with bits[3:0] PWM'd.
3. req_valid pulsed with addr 0x01 while busy. Required: ignored; no extra frame; exactly one done per accepted request.
4. Assert rst_n low after the 5th sclk rising edge. Required: ncs=1, sclk=0, copi=0 immediately; no done pulse; peripheral registers unchanged. A subsequent full write of 0x03<-0xAA succeeds.
5. CLK_DIV=3, addr 0x7F data 0x55. Required: sclk high and low phases exactly 3 cycles each; frame 0xFF55 shifted; peripheral registers unchanged.
6. Protocol monitor throughout: sclk never toggles with ncs=1, and copi is stable from CLK_DIV cycles before each sclk rising edge until its falling edge.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI write-frame controller.
//   Frame layout constants, peripheral register map, FSM state encoding
//   and a helper that packs a write request into a frame.
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam logic RW_WRITE = 1'b1;

    // Peripheral register map
    localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    // {write flag, address, data}, transmitted MSB first
    function automatic logic [FRAME_W-1:0] make_frame(input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] data);
        return {RW_WRITE, addr, data};
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: loadable 8-bit down-counter.
//   clk, rst_n  : clock, async active-low reset
//   i_load      : load i_load_val this cycle (takes priority)
//   i_load_val  : value loaded; a load of N-1 gives a tick N cycles later
//   o_tick      : high while the count is zero (terminal cycle of a phase)
module spi_phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_tick
);

    logic [7:0] r_cnt;

    // Saturates at zero so an idle timer reads as permanently expired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_tick = (r_cnt == 8'd0);

endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI Mode-0 initiator producing 16-bit write frames.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_addr, req_data    : frame bits [14:8] and [7:0]
//   busy                  : high from accept until return to IDLE
//   done                  : one-cycle pulse in the first GAP cycle
//   sclk, ncs, copi       : SPI bus (CPOL=0, CPHA=0, MSB first)
// All outputs are registered.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int GAP      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              ncs,
    output logic              copi
);

    localparam logic [7:0] LD_SETUP = 8'(CS_SETUP - 1);
    localparam logic [7:0] LD_HALF  = 8'(CLK_DIV - 1);
    localparam logic [7:0] LD_HOLD  = 8'(CS_HOLD - 1);
    localparam logic [7:0] LD_GAP   = 8'(GAP - 1);

    spi_state_e         r_state;
    logic [FRAME_W-1:0] r_frame;
    logic [3:0]         r_bit;
    logic               r_high;     // current SHIFT half-period is the sclk-high phase

    logic               w_accept;
    logic               w_tick;
    logic               w_load;
    logic [7:0]         w_load_val;
    logic [FRAME_W-1:0] w_frame;

    assign w_frame  = make_frame(req_addr, req_data);
    assign w_accept = (r_state == ST_IDLE) && req_valid && req_ready;
    // Every state transition reloads the timer with the next phase length.
    assign w_load   = w_accept || ((r_state != ST_IDLE) && w_tick);

    always_comb begin
        w_load_val = 8'd0;
        case (r_state)
            ST_IDLE:  w_load_val = LD_SETUP;
            ST_SETUP: w_load_val = LD_HALF;
            ST_SHIFT: w_load_val = (r_high && r_bit == 4'd0) ? LD_HOLD : LD_HALF;
            ST_HOLD:  w_load_val = LD_GAP;
            default:  w_load_val = 8'd0;
        endcase
    end

    spi_phase_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tick     (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_frame   <= '0;
            r_bit     <= 4'd0;
            r_high    <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sclk      <= 1'b0;
            ncs       <= 1'b1;
            copi      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (w_accept) begin
                        r_frame   <= w_frame;
                        copi      <= w_frame[FRAME_W-1];
                        ncs       <= 1'b0;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        copi    <= r_frame[FRAME_W-1];
                        r_bit   <= 4'd15;
                        r_high  <= 1'b0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (!r_high) begin
                            sclk   <= 1'b1;
                            r_high <= 1'b1;
                        end else begin
                            // End of bit period: sclk falls and copi advances on the same edge
                            sclk   <= 1'b0;
                            r_high <= 1'b0;
                            if (r_bit == 4'd0) begin
                                copi    <= 1'b0;
                                r_state <= ST_HOLD;
                            end else begin
                                r_bit   <= r_bit - 4'd1;
                                r_frame <= {r_frame[FRAME_W-2:0], 1'b0};
                                copi    <= r_frame[FRAME_W-2];
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        ncs     <= 1'b1;
                        done    <= 1'b1;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed bench for spi_controller.
//   Instance 0 uses default parameters, instance 1 uses CLK_DIV=3.
//   A bus monitor per instance reconstructs frames and timing.
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rv [2] = '{1'b0, 1'b0};
    logic [6:0] ra [2] = '{7'h0, 7'h0};
    logic [7:0] rd [2] = '{8'h0, 8'h0};
    logic       rdy_o [2], busy_o [2], done_o [2], sclk_o [2], ncs_o [2], copi_o [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_controller dut (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rdy_o[0]),
        .req_addr(ra[0]), .req_data(rd[0]), .busy(busy_o[0]), .done(done_o[0]),
        .sclk(sclk_o[0]), .ncs(ncs_o[0]), .copi(copi_o[0])
    );

    spi_controller #(.CLK_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rdy_o[1]),
        .req_addr(ra[1]), .req_data(rd[1]), .busy(busy_o[1]), .done(done_o[1]),
        .sclk(sclk_o[1]), .ncs(ncs_o[1]), .copi(copi_o[1])
    );

    // ---------------- bus monitor ----------------
    int cyc = 0;
    logic ps [2] = '{1'b0, 1'b0};
    logic pn [2] = '{1'b1, 1'b1};
    logic pc [2] = '{1'b0, 1'b0};
    logic pd [2] = '{1'b0, 1'b0};
    int run [2], stab [2], low_cnt [2], rises_f [2], viol [2], done_cnt [2], frames [2];
    int last_low [2], last_rises [2], last_gap [2], rise_cyc [2], acc_cyc [2], acc_delta [2];
    int hi_min [2] = '{999, 999};
    int hi_max [2] = '{0, 0};
    int lo_min [2] = '{999, 999};
    int lo_max [2] = '{0, 0};
    logic [15:0] rx [2], last_rx [2], prev_rx [2];

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            logic s, n, c;
            int cd;
            s  = sclk_o[k];
            n  = ncs_o[k];
            c  = copi_o[k];
            cd = (k == 0) ? 4 : 3;
            if (n && pn[k] && s != ps[k]) viol[k]++;      // sclk toggling while deselected
            if (c != pc[k] && s) viol[k]++;               // copi moved at/after a rising edge
            stab[k] = (c != pc[k]) ? 1 : stab[k] + 1;
            if (done_o[k]) begin
                done_cnt[k]++;
                if (pd[k]) viol[k]++;
            end
            if (rv[k] && rdy_o[k]) begin
                acc_delta[k] = cyc - acc_cyc[k];
                acc_cyc[k]   = cyc;
            end
            if (!n && pn[k]) begin
                low_cnt[k]  = 1;
                rx[k]       = 16'h0;
                rises_f[k]  = 0;
                last_gap[k] = cyc - rise_cyc[k];
            end else if (!n) begin
                low_cnt[k]++;
            end
            if (n && !pn[k]) begin
                last_low[k]   = low_cnt[k];
                last_rises[k] = rises_f[k];
                prev_rx[k]    = last_rx[k];
                last_rx[k]    = rx[k];
                frames[k]++;
                rise_cyc[k]   = cyc;
            end
            if (s != ps[k]) begin
                if (s) begin
                    if (!n) begin
                        rx[k] = {rx[k][14:0], c};
                        if (stab[k] < cd + 1) viol[k]++;
                        if (rises_f[k] > 0) begin
                            if (run[k] < lo_min[k]) lo_min[k] = run[k];
                            if (run[k] > lo_max[k]) lo_max[k] = run[k];
                        end
                        rises_f[k]++;
                    end
                end else if (!n) begin
                    if (run[k] < hi_min[k]) hi_min[k] = run[k];
                    if (run[k] > hi_max[k]) hi_max[k] = run[k];
                end
                run[k] = 1;
            end else begin
                run[k]++;
            end
            ps[k] = s;
            pn[k] = n;
            pc[k] = c;
            pd[k] = done_o[k];
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int k, input logic [6:0] a, input logic [7:0] d);
        int t = 0;
        @(posedge clk); #1;
        rv[k] = 1'b1; ra[k] = a; rd[k] = d;
        @(negedge clk);
        while (!rdy_o[k] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("accept_wait", 32'(t < 3000), 1);
        @(posedge clk); #1;
        // Scramble the request bus to show it is not used after accept
        rv[k] = 1'b0; ra[k] = ~a; rd[k] = ~d;
    endtask

    task automatic wait_idle(input int k);
        int t = 0;
        @(negedge clk);
        while (!(rdy_o[k] && !busy_o[k]) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_wait", 32'(t < 3000), 1);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dc, fr, n5, t;
        logic p;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs0", {26'd0, ncs_o[0], sclk_o[0], copi_o[0], rdy_o[0], busy_o[0], done_o[0]}, 32'b100000);
        chk("rst_outs1", {26'd0, ncs_o[1], sclk_o[1], copi_o[1], rdy_o[1], busy_o[1], done_o[1]}, 32'b100000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {30'd0, rdy_o[0], rdy_o[1]}, 32'b11);

        // 1: duty-cycle write with default timing
        dc = done_cnt[0];
        send(0, 7'h04, 8'h80);
        chk("busy_after_acc", {29'd0, busy_o[0], rdy_o[0], ncs_o[0]}, 32'b100);
        wait_idle(0);
        chk("t1_frame", last_rx[0], 32'h8480);
        chk("t1_ncs_low", last_low[0], 132);
        chk("t1_rises", last_rises[0], 16);
        chk("t1_done", done_cnt[0] - dc, 1);
        chk("t1_hi_min", hi_min[0], 4);
        chk("t1_hi_max", hi_max[0], 4);
        chk("t1_lo_min", lo_min[0], 4);
        chk("t1_lo_max", lo_max[0], 4);

        // 2: back-to-back writes with valid held high
        dc = done_cnt[0];
        @(posedge clk); #1;
        rv[0] = 1'b1; ra[0] = 7'h00; rd[0] = 8'hFF;
        @(posedge clk); #1;                      // ready was high: accepted on this edge
        ra[0] = 7'h02; rd[0] = 8'h0F;
        t = 0;
        @(negedge clk);
        while (!rdy_o[0] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("t2_second_wait", 32'(t < 3000), 1);
        @(posedge clk); #1;
        rv[0] = 1'b0;
        wait_idle(0);
        chk("t2_frame_a", prev_rx[0], 32'h80FF);
        chk("t2_frame_b", last_rx[0], 32'h820F);
        chk("t2_ncs_gap", last_gap[0], 5);
        chk("t2_acc_to_acc", acc_delta[0], 137);
        chk("t2_done", done_cnt[0] - dc, 2);

        // 3: request pulsed while busy is ignored
        dc = done_cnt[0];
        fr = frames[0];
        send(0, 7'h02, 8'h5A);
        repeat (20) @(posedge clk);
        #1;
        rv[0] = 1'b1; ra[0] = 7'h01; rd[0] = 8'h77;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        wait_idle(0);
        repeat (30) @(negedge clk);
        #1;
        chk("t3_frames", frames[0] - fr, 1);
        chk("t3_done", done_cnt[0] - dc, 1);
        chk("t3_frame", last_rx[0], 32'h825A);
        chk("t3_idle", {30'd0, ncs_o[0], busy_o[0]}, 32'b10);

        // 4: reset after the 5th rising edge, then a clean write
        dc = done_cnt[0];
        send(0, 7'h01, 8'hC3);
        n5 = 0; t = 0; p = 1'b0;
        while (n5 < 5 && t < 3000) begin
            @(negedge clk);
            if (sclk_o[0] && !p) n5++;
            p = sclk_o[0];
            t++;
        end
        chk("t4_rise5", n5, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_midrst_outs", {26'd0, ncs_o[0], sclk_o[0], copi_o[0], rdy_o[0], busy_o[0], done_o[0]}, 32'b100000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("t4_no_done", done_cnt[0] - dc, 0);
        chk("t4_partial_rises", last_rises[0], 5);
        chk("t4_ready", rdy_o[0], 1);
        send(0, 7'h03, 8'hAA);
        wait_idle(0);
        chk("t4_frame", last_rx[0], 32'h83AA);
        chk("t4_done", done_cnt[0] - dc, 1);
        chk("t4_ncs_low", last_low[0], 132);

        // 5: CLK_DIV=3 instance, out-of-map address sent verbatim
        dc = done_cnt[1];
        send(1, 7'h7F, 8'h55);
        wait_idle(1);
        chk("t5_frame", last_rx[1], 32'hFF55);
        chk("t5_ncs_low", last_low[1], 100);
        chk("t5_rises", last_rises[1], 16);
        chk("t5_hi_min", hi_min[1], 3);
        chk("t5_hi_max", hi_max[1], 3);
        chk("t5_lo_min", lo_min[1], 3);
        chk("t5_lo_max", lo_max[1], 3);
        chk("t5_done", done_cnt[1] - dc, 1);

        // 6: protocol monitor over the whole run
        chk("t6_viol0", viol[0], 0);
        chk("t6_viol1", viol[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
